// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between NREQ valid/ready requesters.
// Define ALU_ARB_LOCK_EN to let a requester keep its grant across ops via req_lock.
module alu_share_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int ID_W   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*3-1:0]      req_ctrl,
  input  logic [NREQ-1:0]        req_lock,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [2:0]             alu_ctrl,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic [3:0]             rsp_flags
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t              state_q;
  logic [ID_W-1:0]     ptr_q, id_q, gnt, ptr_nxt;
  logic                gnt_vld;
  logic [DATA_W-1:0]   a_q, b_q, res_q;
  logic [2:0]          ctrl_q;
  logic [3:0]          flags_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_valid_q;
`ifdef ALU_ARB_LOCK_EN
  logic                lock_vld_q;
  logic [ID_W-1:0]     lock_id_q;
`else
  logic                unused_lock;
  assign unused_lock = ^req_lock;
`endif

  function automatic logic [ID_W-1:0] wrap(input int j);
    return ID_W'((j >= NREQ) ? j - NREQ : j);
  endfunction

  // Scan downward so the last hit is the nearest valid requester at or above the pointer.
  always_comb begin
    gnt = ptr_q;
    gnt_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[wrap(int'(ptr_q) + k)]) begin
        gnt = wrap(int'(ptr_q) + k);
        gnt_vld = 1'b1;
      end
    end
`ifdef ALU_ARB_LOCK_EN
    if (lock_vld_q) begin
      gnt = lock_id_q;
      gnt_vld = req_valid[lock_id_q];
    end
`endif
  end

  assign ptr_nxt    = (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + 1'b1;
  assign req_ready  = (rst && state_q == IDLE && gnt_vld) ? NREQ'(1) << gnt : '0;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      res_q       <= '0;
      flags_q     <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_vld_q  <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            a_q     <= req_a[gnt*DATA_W +: DATA_W];
            b_q     <= req_b[gnt*DATA_W +: DATA_W];
            ctrl_q  <= req_ctrl[gnt*3 +: 3];
            id_q    <= gnt;
            state_q <= EXEC;
`ifdef ALU_ARB_LOCK_EN
            lock_vld_q <= req_lock[gnt];
            lock_id_q  <= gnt;
            ptr_q      <= req_lock[gnt] ? ptr_q : ptr_nxt;
`else
            ptr_q   <= ptr_nxt;
`endif
          end
`ifdef ALU_ARB_LOCK_EN
          else lock_vld_q <= 1'b0;
`endif
        end
        EXEC: begin
          res_q       <= alu_result;
          flags_q     <= alu_flags;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of grant order, latency, backpressure and reset
// against a behavioural ALU wired to the arbiter's ALU port.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_lock = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [5:0]  req_ctrl = '0;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_flags, rsp_flags;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [0:0]  rsp_id;
  int          errors = 0, checks = 0;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_lock(req_lock),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: flags {carry, overflow, zero, negative}
  logic [32:0] sum, dif;
  logic [31:0] res;
  logic        c, v;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    dif = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    res = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_ctrl)
      3'b000: begin res = sum[31:0]; c = sum[32]; v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]); end
      3'b001: begin res = dif[31:0]; c = dif[32]; v = (alu_a[31] != alu_b[31]) && (dif[31] != alu_a[31]); end
      3'b010: res = alu_a & alu_b;
      3'b011: res = alu_a | alu_b;
      3'b101: res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: res = '0;
    endcase
    alu_result = res;
    alu_flags  = {c, v, res == 32'd0, res[31]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] c_i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_ctrl[i*3 +: 3] = c_i;
    req_valid[i] = 1'b1;
  endtask

  // Issue one op from requester i, starting at a negedge; ends at the negedge where rsp_valid should rise.
  task automatic do_op(input string tag, input int i, input logic [2:0] c_i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef, input bit cf);
    int n = 0;
    set_req(i, c_i, a, b);
    #1;
    while (!req_ready[i] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_grant"}, req_ready, 2'b01 << i);
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    chk({tag, "_exec_valid"}, rsp_valid, 1'b0);
    chk({tag, "_alu_a"}, alu_a, a);
    @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_id"}, rsp_id, i);
    chk({tag, "_result"}, rsp_result, er);
    if (cf) chk({tag, "_flags"}, rsp_flags, ef);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk({tag, "_timeout"}, rsp_valid, 1'b1);
  endtask

  logic [1:0]  exp_order [4];
  logic [31:0] held;
  int          n0;

  initial begin
    // Reset state
    #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_outputs", {rsp_result, rsp_flags, rsp_id, alu_a, alu_b, alu_ctrl}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Reset in the middle of EXEC
    set_req(0, 3'b000, 32'd3, 32'd4);
    @(posedge clk);
    @(negedge clk);
    chk("rst_pre_alu_a", alu_a, 32'd3);
    req_valid = 2'b11;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", rsp_valid, 1'b0);
    chk("rst_async_ready", req_ready, 2'b00);
    chk("rst_async_out", {rsp_result, rsp_flags, rsp_id, alu_a, alu_b, alu_ctrl}, 0);
    @(negedge clk);
    chk("rst_hold_ready", req_ready, 2'b00);
    rst = 1'b1;
    #1;
    chk("rst_first_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    // Basic ops
    do_op("add_ovf", 0, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101, 1'b1);
    @(negedge clk);
    chk("add_ovf_popped", rsp_valid, 1'b0);
    do_op("sub_zero", 1, 3'b001, 32'd5, 32'd5, 32'd0, 4'b1010, 1'b1);
    @(negedge clk);
    do_op("slt", 1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 1'b0);
    @(negedge clk);
    // Backpressure: response held while rsp_ready=0
    rsp_ready = 1'b0;
    do_op("bp_and", 0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 1'b1);
    held = rsp_result;
    set_req(1, 3'b011, 32'h0000_F0F0, 32'h0000_FF00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_stable", rsp_result, held);
      chk("bp_no_ready", req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_regrant", req_ready, 2'b10);
    do_op("bp_or", 1, 3'b011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 4'b0000, 1'b1);
    @(negedge clk);
    // Both requesters continuously valid: strict alternation
    set_req(0, 3'b000, 32'd1, 32'd2);
    set_req(1, 3'b001, 32'd10, 32'd3);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("rr");
      chk("rr_id", rsp_id, k % 2);
      chk("rr_result", rsp_result, (k % 2) ? 32'd7 : 32'd3);
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    // Lock: req0 holds the grant for two ops when the feature is built in
`ifdef ALU_ARB_LOCK_EN
    exp_order = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    n0 = 0;
    req_lock = 2'b01;
    set_req(0, 3'b000, 32'd50, 32'd1);
    set_req(1, 3'b000, 32'd100, 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("lock");
      chk("lock_order", rsp_id, exp_order[k]);
      if (rsp_id == 1'b0) n0++;
      req_lock[0] = (n0 < 2);
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    req_lock = 2'b00;
    @(negedge clk);
    chk("idle_end", {rsp_valid, req_ready}, 3'b000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
